// File: rtl/karatsuba_pkg.sv
// Shared constants, state encoding and the Karatsuba recombination step for
// the sequential 64x64 multiplier.
package karatsuba_pkg;

  localparam int unsigned HALF_W      = 32;
  localparam int unsigned OPER_W      = 2 * HALF_W;
  localparam int unsigned SUM_W       = HALF_W + 1;
  localparam int unsigned Z_W         = 2 * HALF_W;
  localparam int unsigned MID_W       = 66;
  localparam int unsigned PROD_W      = 128;
  localparam int unsigned MUL_LAT_MAX = 3;
  localparam int unsigned CNT_W       = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_LO  = 3'd1,
    MUL_HI  = 3'd2,
    MUL_MID = 3'd3,
    COMBINE = 3'd4,
    DONE    = 3'd5
  } state_e;

  // z1 - z2 - z0 cannot underflow; the weighted sum fits in 128 bits.
  function automatic logic [PROD_W-1:0] kara_combine(
    input logic [Z_W-1:0]   z0,
    input logic [Z_W-1:0]   z2,
    input logic [MID_W-1:0] z1
  );
    logic [MID_W-1:0] mid;
    mid = z1 - MID_W'(z2) - MID_W'(z0);
    return (PROD_W'(z2) << (2 * HALF_W)) + (PROD_W'(mid) << HALF_W) + PROD_W'(z0);
  endfunction

endpackage

// File: rtl/mul33_pipe.sv
// Unsigned 33x33 -> 66 multiplier with MUL_LAT output register stages;
// datapath registers carry no reset.
module mul33_pipe
  import karatsuba_pkg::*;
#(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic             clk,
  input  logic [SUM_W-1:0] a_i,
  input  logic [SUM_W-1:0] b_i,
  output logic [MID_W-1:0] p_o
);

  logic [MID_W-1:0] prod_c;
  assign prod_c = MID_W'(a_i) * MID_W'(b_i);

  if (MUL_LAT == 0) begin : g_comb
    assign p_o = prod_c;
  end else begin : g_pipe
    logic [MID_W-1:0] stage_q [MUL_LAT];

    always_ff @(posedge clk) begin
      stage_q[0] <= prod_c;
      for (int unsigned s = 1; s < MUL_LAT; s++) begin
        stage_q[s] <= stage_q[s-1];
      end
    end

    assign p_o = stage_q[MUL_LAT-1];
  end

endmodule

// File: rtl/karatsuba_seq_ctrl.sv
// Sequential 64x64 Karatsuba multiplier: one shared 33x33 multiplier is
// stepped through z0, z2 and z1, then the partials are recombined.
module karatsuba_seq_ctrl
  import karatsuba_pkg::*;
#(
  parameter int unsigned MUL_LAT = 1,
  parameter int unsigned HALF_W  = karatsuba_pkg::HALF_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*HALF_W-1:0] x,
  input  logic [2*HALF_W-1:0] y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PROD_W-1:0]   product,
  output logic                busy
);

  if (HALF_W != karatsuba_pkg::HALF_W) begin : g_bad_half_w
    $error("karatsuba_seq_ctrl: HALF_W must be 32");
  end
  if (MUL_LAT > MUL_LAT_MAX) begin : g_bad_mul_lat
    $error("karatsuba_seq_ctrl: MUL_LAT must be 0..3");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HALF_W-1:0]  xl_q, xl_d, xh_q, xh_d, yl_q, yl_d, yh_q, yh_d;
  logic [SUM_W-1:0]   sx_q, sx_d, sy_q, sy_d;
  logic [Z_W-1:0]     z0_q, z0_d, z2_q, z2_d;
  logic [MID_W-1:0]   z1_q, z1_d;
  logic [PROD_W-1:0]  product_q, product_d;
  logic               out_valid_q, out_valid_d;

  logic [SUM_W-1:0]   mul_a, mul_b;
  logic [MID_W-1:0]   mul_p;
  logic               phase_last;

  mul33_pipe #(.MUL_LAT(MUL_LAT)) u_mul (
    .clk (clk),
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  assign phase_last = (cnt_q == CNT_W'(MUL_LAT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      xl_q        <= '0;
      xh_q        <= '0;
      yl_q        <= '0;
      yh_q        <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      z0_q        <= '0;
      z2_q        <= '0;
      z1_q        <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      xl_q        <= xl_d;
      xh_q        <= xh_d;
      yl_q        <= yl_d;
      yh_q        <= yh_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      z0_q        <= z0_d;
      z2_q        <= z2_d;
      z1_q        <= z1_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Operand mux into the shared multiplier, phase sequencing and capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    xl_d        = xl_q;
    xh_d        = xh_q;
    yl_d        = yl_q;
    yh_d        = yh_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    z0_d        = z0_q;
    z2_d        = z2_q;
    z1_d        = z1_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    mul_a       = '0;
    mul_b       = '0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          xl_d    = x[HALF_W-1:0];
          xh_d    = x[2*HALF_W-1:HALF_W];
          yl_d    = y[HALF_W-1:0];
          yh_d    = y[2*HALF_W-1:HALF_W];
          sx_d    = SUM_W'(x[HALF_W-1:0]) + SUM_W'(x[2*HALF_W-1:HALF_W]);
          sy_d    = SUM_W'(y[HALF_W-1:0]) + SUM_W'(y[2*HALF_W-1:HALF_W]);
          cnt_d   = '0;
          state_d = MUL_LO;
        end
      end
      MUL_LO: begin
        mul_a = {1'b0, xl_q};
        mul_b = {1'b0, yl_q};
        if (phase_last) begin
          z0_d    = mul_p[Z_W-1:0];
          cnt_d   = '0;
          state_d = MUL_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MUL_HI: begin
        mul_a = {1'b0, xh_q};
        mul_b = {1'b0, yh_q};
        if (phase_last) begin
          z2_d    = mul_p[Z_W-1:0];
          cnt_d   = '0;
          state_d = MUL_MID;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MUL_MID: begin
        mul_a = sx_q;
        mul_b = sy_q;
        if (phase_last) begin
          z1_d    = mul_p;
          cnt_d   = '0;
          state_d = COMBINE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      COMBINE: begin
        product_d   = kara_combine(z0_q, z2_q, z1_q);
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// Bench for karatsuba_seq_ctrl: three instances (MUL_LAT 1, 0, 3) checked every
// cycle against a transaction-level timing/product model plus literal results.
module tb_karatsuba_seq_ctrl;

  localparam int NI = 3;
  localparam int PH_IDLE = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_SHOW = 2;
  localparam int NRAND = 2000;

  logic clk;
  logic         rst_s       [NI];
  logic         in_valid_s  [NI];
  logic         in_ready_s  [NI];
  logic [63:0]  x_s         [NI];
  logic [63:0]  y_s         [NI];
  logic         out_valid_s [NI];
  logic         out_ready_s [NI];
  logic [127:0] product_s   [NI];
  logic         busy_s      [NI];

  int mlat [NI] = '{1, 0, 3};

  int n_total = 0;
  int n_bad   = 0;

  // model state, owned by the compare process
  int           m_ph    [NI];
  int           m_rem   [NI];
  logic [127:0] m_prod  [NI];
  bit           m_fresh [NI];
  bit           show_new[NI];
  bit           armed   [NI];
  int           lat_cnt [NI];
  int           acc_cnt [NI];
  int           del_cnt [NI];
  int           abt_cnt [NI];
  int           lit_used[NI];

  // written by the stimulus process
  int           lit_seq [NI];
  logic [127:0] lit_prod[NI];
  int           lit_lat [NI];
  int           tmo     [NI];
  bit           final_req  = 0;
  bit           final_done = 0;

  karatsuba_seq_ctrl #(.MUL_LAT(1), .HALF_W(32)) u_dut0 (
    .clk(clk), .rst(rst_s[0]), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .x(x_s[0]), .y(y_s[0]), .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
    .product(product_s[0]), .busy(busy_s[0]));

  karatsuba_seq_ctrl #(.MUL_LAT(0), .HALF_W(32)) u_dut1 (
    .clk(clk), .rst(rst_s[1]), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .x(x_s[1]), .y(y_s[1]), .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
    .product(product_s[1]), .busy(busy_s[1]));

  karatsuba_seq_ctrl #(.MUL_LAT(3), .HALF_W(32)) u_dut2 (
    .clk(clk), .rst(rst_s[2]), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
    .x(x_s[2]), .y(y_s[2]), .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]),
    .product(product_s[2]), .busy(busy_s[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int i, input logic [127:0] got, input logic [127:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s inst=%0d t=%0t got=%0h want=%0h", nm, i, $time, got, want);
    end
  endtask

  // Compare process: checks every instance each cycle, then advances the model.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (armed[i]) begin
        chk("out_valid", i, 128'(out_valid_s[i]), 128'(m_ph[i] == PH_SHOW));
        chk("busy", i, 128'(busy_s[i]), 128'(m_ph[i] != PH_IDLE));
        chk("in_ready", i, 128'(in_ready_s[i]), 128'((m_ph[i] == PH_IDLE) && !rst_s[i]));
        if (m_ph[i] == PH_SHOW) begin
          chk("product", i, product_s[i], m_prod[i]);
          if (show_new[i] && lit_seq[i] != lit_used[i]) begin
            chk("lit_latency", i, 128'(lat_cnt[i]), 128'(lit_lat[i]));
            chk("lit_product", i, product_s[i], lit_prod[i]);
            lit_used[i] = lit_seq[i];
          end
        end else if (m_fresh[i]) begin
          chk("product_after_reset", i, product_s[i], 128'd0);
        end
      end

      lat_cnt[i]++;
      if (rst_s[i]) begin
        if (m_ph[i] != PH_IDLE) abt_cnt[i]++;
        m_ph[i]     = PH_IDLE;
        m_fresh[i]  = 1'b1;
        show_new[i] = 1'b0;
        armed[i]    = 1'b1;
      end else begin
        case (m_ph[i])
          PH_IDLE: if (in_valid_s[i]) begin
            m_ph[i]    = PH_WAIT;
            m_rem[i]   = 3 * (mlat[i] + 1) + 1;
            m_prod[i]  = 128'(x_s[i]) * 128'(y_s[i]);
            lat_cnt[i] = 0;
            acc_cnt[i]++;
          end
          PH_WAIT: begin
            m_rem[i]--;
            if (m_rem[i] == 0) begin
              m_ph[i]     = PH_SHOW;
              show_new[i] = 1'b1;
              m_fresh[i]  = 1'b0;
            end
          end
          default: begin
            show_new[i] = 1'b0;
            if (out_ready_s[i]) begin
              m_ph[i] = PH_IDLE;
              del_cnt[i]++;
            end
          end
        endcase
      end
    end

    if (final_req && !final_done) begin
      chk("delivered", 0, 128'(del_cnt[0]), 128'd6);
      chk("aborted", 0, 128'(abt_cnt[0]), 128'd1);
      chk("delivered", 1, 128'(del_cnt[1]), 128'(NRAND + 1));
      chk("delivered", 2, 128'(del_cnt[2]), 128'(NRAND + 1));
      for (int i = 0; i < NI; i++) begin
        chk("accept_balance", i, 128'(acc_cnt[i]), 128'(del_cnt[i] + abt_cnt[i]));
        chk("timeouts", i, 128'(tmo[i]), 128'd0);
      end
      final_done = 1'b1;
    end
  end

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 4))
      0:       v = '1;
      1:       v = {32'hFFFF_FFFF, 32'($urandom)};
      2:       v = {32'($urandom), 32'hFFFF_FFFF};
      default: v = {32'($urandom), 32'($urandom)};
    endcase
    return v;
  endfunction

  // One transaction on instance i; in_valid stays high with junk while busy.
  task automatic do_txn(input int i, input logic [63:0] xv, input logic [63:0] yv,
                        input int hold, input bit use_lit, input logic [127:0] lp, input int ll);
    int k;
    if (use_lit) begin
      lit_prod[i] = lp;
      lit_lat[i]  = ll;
      lit_seq[i]++;
    end
    out_ready_s[i] = (hold == 0);
    k = 0;
    while (!in_ready_s[i] && k < 100) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 100) tmo[i]++;
    in_valid_s[i] = 1'b1;
    x_s[i] = xv;
    y_s[i] = yv;
    @(posedge clk); #1;
    x_s[i] = pick();
    y_s[i] = pick();
    k = 0;
    while (!out_valid_s[i] && k < 64) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 64) tmo[i]++;
    in_valid_s[i] = 1'b0;
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
      end
      out_ready_s[i] = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_run(input int i, input int lat_lit);
    int acc;
    int cyc;
    do_txn(i, 64'd3, 64'd5, 0, 1'b1, 128'd15, lat_lit);
    acc = 0;
    cyc = 0;
    while (acc < NRAND && cyc < 90000) begin
      in_valid_s[i]  = ($urandom_range(0, 3) != 0);
      x_s[i]         = pick();
      y_s[i]         = pick();
      out_ready_s[i] = 1'($urandom_range(0, 1));
      if (in_valid_s[i] && in_ready_s[i]) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    if (acc < NRAND) tmo[i]++;
    in_valid_s[i]  = 1'b0;
    out_ready_s[i] = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic directed_run();
    do_txn(0, 64'd3, 64'd5, 0, 1'b1, 128'd15, 7);
    do_txn(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1,
           128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 7);
    do_txn(0, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 0, 1'b1,
           128'h0000_0000_0000_0001_0000_0000_0000_0000, 7);
    do_txn(0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0000, 0, 1'b1,
           128'h0000_0000_FFFF_FFFF_0000_0000, 7);
    do_txn(0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 10, 1'b0, 128'd0, 0);
    // reset while MUL_MID is in progress: the result must never appear
    out_ready_s[0] = 1'b1;
    in_valid_s[0]  = 1'b1;
    x_s[0] = 64'hDEAD_BEEF_0BAD_F00D;
    y_s[0] = 64'hFEED_FACE_CAFE_BABE;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_s[0] = 1'b1;
    @(posedge clk); #1;
    rst_s[0] = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    // reset wins over a simultaneous in_valid
    rst_s[0] = 1'b1;
    in_valid_s[0] = 1'b1;
    x_s[0] = 64'd11;
    y_s[0] = 64'd13;
    @(posedge clk); #1;
    rst_s[0] = 1'b0;
    in_valid_s[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    do_txn(0, 64'd7, 64'd9, 0, 1'b1, 128'd63, 7);
    repeat (5) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int k;
    for (int i = 0; i < NI; i++) begin
      rst_s[i] = 1'b1; in_valid_s[i] = 1'b0; out_ready_s[i] = 1'b1;
      x_s[i] = '0; y_s[i] = '0;
      m_ph[i] = PH_IDLE; m_rem[i] = 0; m_prod[i] = '0; m_fresh[i] = 1'b1;
      show_new[i] = 1'b0; armed[i] = 1'b0; lat_cnt[i] = 0;
      acc_cnt[i] = 0; del_cnt[i] = 0; abt_cnt[i] = 0;
      lit_used[i] = 0; lit_seq[i] = 0; lit_prod[i] = '0; lit_lat[i] = 0; tmo[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) rst_s[i] = 1'b0;

    fork
      directed_run();
      rand_run(1, 4);
      rand_run(2, 13);
    join

    final_req = 1'b1;
    k = 0;
    while (!final_done && k < 10) begin
      @(posedge clk); #1; k++;
    end
    if (!final_done) begin
      $display("FAIL final_check got=not_run want=run");
      $fatal(1, "final check did not run");
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
